alu_result_stage: RTL and testbench

//  Registered output stage sitting directly downstream of the ALU datapath (shifters, adder, logic unit).

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_flag_gen.sv | 25 ++
 rtl/alu_result_stage.sv | 99 +++++++++
 tb/tb_alu_result_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: NZCV flag record and bit positions used by all ALU units.
package alu_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV derivation from an ALU result plus the producing unit's carry/overflow.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] result,
  input  logic         carry,
  input  logic         overflow,
  output alu_flags_t   flags
);

  logic [3:0] flag_vec;

  always_comb begin
    flag_vec         = '0;
    flag_vec[FLAG_N] = result[N-1];
    flag_vec[FLAG_Z] = (result == '0);
    flag_vec[FLAG_C] = carry;
    flag_vec[FLAG_V] = overflow;
  end

  assign flags = alu_flags_t'(flag_vec);

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: 2-entry skid buffer carrying result+NZCV, plus the architectural flag register.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  input  logic         in_carry,
  input  logic         in_overflow,
  input  logic         in_flag_we,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_flags,
  output logic [3:0]   arch_flags
);

  alu_flags_t   flags_p0;

  logic         main_valid_p1;
  logic [N-1:0] main_result_p1;
  alu_flags_t   main_flags_p1;
  logic         main_we_p1;

  logic         skid_valid_p1;
  logic [N-1:0] skid_result_p1;
  alu_flags_t   skid_flags_p1;
  logic         skid_we_p1;

  logic         in_ready_r;
  alu_flags_t   arch_flags_r;

  logic         accept;
  logic         emit;

  alu_flag_gen #(.N(N)) u_flag_gen (
    .result   (in_result),
    .carry    (in_carry),
    .overflow (in_overflow),
    .flags    (flags_p0)
  );

  assign accept = in_valid & in_ready_r;
  assign emit   = main_valid_p1 & out_ready;

  // Stage p0 -> p1: capture into main or skid; skid refills main on emit
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_p1  <= 1'b0;
      main_result_p1 <= '0;
      main_flags_p1  <= '0;
      main_we_p1     <= 1'b0;
      skid_valid_p1  <= 1'b0;
      skid_result_p1 <= '0;
      skid_flags_p1  <= '0;
      skid_we_p1     <= 1'b0;
      in_ready_r     <= 1'b1;
      arch_flags_r   <= '0;
    end else begin
      if (emit && main_we_p1) begin
        arch_flags_r <= main_flags_p1;
      end

      // in_ready is low whenever skid is full, so accept cannot coincide with a skid drain
      if (emit && skid_valid_p1) begin
        main_valid_p1  <= 1'b1;
        main_result_p1 <= skid_result_p1;
        main_flags_p1  <= skid_flags_p1;
        main_we_p1     <= skid_we_p1;
        skid_valid_p1  <= 1'b0;
        in_ready_r     <= 1'b1;
      end else if (accept && (!main_valid_p1 || emit)) begin
        main_valid_p1  <= 1'b1;
        main_result_p1 <= in_result;
        main_flags_p1  <= flags_p0;
        main_we_p1     <= in_flag_we;
      end else if (accept) begin
        skid_valid_p1  <= 1'b1;
        skid_result_p1 <= in_result;
        skid_flags_p1  <= flags_p0;
        skid_we_p1     <= in_flag_we;
        in_ready_r     <= 1'b0;
      end else if (emit) begin
        main_valid_p1  <= 1'b0;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = main_valid_p1;
  assign out_result = main_result_p1;
  assign out_flags  = main_flags_p1;
  assign arch_flags = arch_flags_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic against a queue model.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic       in_carry;
  logic       in_overflow;
  logic       in_flag_we;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic [3:0] arch_flags;

  alu_result_stage #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_carry    (in_carry),
    .in_overflow (in_overflow),
    .in_flag_we  (in_flag_we),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .arch_flags  (arch_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;
    logic [3:0] fl;
    logic       we;
  } beat_t;

  // Reference: ordered list of beats held by the stage (at most two), flags register, ready register
  beat_t      q[$];
  logic [3:0] m_arch;
  logic       m_ready;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nzcv(input logic [3:0] r, input logic c, input logic v);
    return {r[3], (r == 4'd0), c, v};
  endfunction

  task automatic step(input logic v, input logic [3:0] r, input logic c, input logic o,
                      input logic we, input logic ordy, input logic rs);
    logic  acc;
    logic  emt;
    beat_t b;
    rst         = rs;
    in_valid    = v;
    in_result   = r;
    in_carry    = c;
    in_overflow = o;
    in_flag_we  = we;
    out_ready   = ordy;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_arch  = 4'd0;
      m_ready = 1'b1;
    end else begin
      acc = v && m_ready;
      emt = (q.size() > 0) && ordy;
      if (emt) begin
        b = q.pop_front();
        if (b.we) m_arch = b.fl;
      end
      if (acc) begin
        b.res = r;
        b.fl  = nzcv(r, c, o);
        b.we  = we;
        q.push_back(b);
      end
      m_ready = (q.size() < 2);
    end
    #1;
    check("out_valid", {7'd0, out_valid}, {7'd0, q.size() > 0});
    check("in_ready", {7'd0, in_ready}, {7'd0, m_ready});
    check("arch_flags", {4'd0, arch_flags}, {4'd0, m_arch});
    if (q.size() > 0) begin
      check("out_result", {4'd0, out_result}, {4'd0, q[0].res});
      check("out_flags", {4'd0, out_flags}, {4'd0, q[0].fl});
    end
  endtask

  initial begin
    m_arch  = 4'd0;
    m_ready = 1'b1;
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_carry = 1'b0;
    in_overflow = 1'b0; in_flag_we = 1'b0; out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted: nothing captured
    step(1, 4'hF, 1, 1, 1, 0, 1);
    step(1, 4'hA, 1, 1, 1, 0, 1);
    check("rst_out_result", {4'd0, out_result}, 8'd0);
    check("rst_out_flags", {4'd0, out_flags}, 8'd0);
    check("rst_arch", {4'd0, arch_flags}, 8'd0);

    // Single beat with flag write
    step(1, 4'b1000, 1, 0, 1, 1, 0);
    check("single_flags", {4'd0, out_flags}, 8'b0000_1010);
    step(0, 4'd0, 0, 0, 0, 1, 0);
    check("single_arch", {4'd0, arch_flags}, 8'b0000_1010);

    // Zero result without flag write
    step(1, 4'd0, 0, 0, 0, 1, 0);
    check("zero_flags", {4'd0, out_flags}, 8'b0000_0100);
    step(0, 4'd0, 0, 0, 0, 1, 0);
    check("zero_arch_hold", {4'd0, arch_flags}, 8'b0000_1010);

    // Back-pressure: third beat must wait upstream
    step(1, 4'd1, 0, 0, 1, 0, 0);
    step(1, 4'd2, 0, 1, 1, 0, 0);
    check("bp_ready_low", {7'd0, in_ready}, 8'd0);
    step(1, 4'd3, 1, 0, 1, 0, 0);
    check("bp_main_hold", {4'd0, out_result}, 8'd1);
    step(1, 4'd3, 1, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 4'd0, 0, 0, 0, 1, 0);

    // Streaming 0..15, no bubbles
    for (int i = 0; i < 16; i++) begin
      step(1, 4'(i), i[0], i[1], 1, 1, 0);
      check("stream_result", {4'd0, out_result}, 8'(i));
    end
    step(0, 4'd0, 0, 0, 0, 1, 0);

    // Reset with both entries full
    step(1, 4'd5, 1, 1, 1, 0, 0);
    step(1, 4'd6, 0, 0, 1, 0, 0);
    step(1, 4'd7, 0, 0, 1, 1, 1);
    check("midrst_valid", {7'd0, out_valid}, 8'd0);
    check("midrst_ready", {7'd0, in_ready}, 8'd1);
    check("midrst_arch", {4'd0, arch_flags}, 8'd0);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
